// File: rtl/jtpopeye_romarb_pkg.sv
// jtpopeye_romarb_pkg: shared types and defaults for the Popeye ROM arbiter
// Holds the arbiter state encoding, default SDRAM word bases and the
// little-endian byte-lane selector used by the requester caches.
package jtpopeye_romarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ACK,
        ST_WAIT_RDY
    } state_t;

    localparam logic [21:0] CPU_OFFSET_DEF = 22'h00_0000;
    localparam logic [21:0] OBJ_OFFSET_DEF = 22'h00_4000;
    localparam int          TAG_W          = 13;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] s);
        return w[8*s +: 8];
    endfunction

endpackage

// File: rtl/jtpopeye_romarb_cache.sv
// jtpopeye_romarb_cache: one-entry word cache for a single ROM requester
// Ports: clk/rst_n clock and async active-low reset; i_clr invalidates;
// i_we/i_wtag/i_wdata fill the entry; i_en/i_tag qualify the hit;
// i_bsel picks the byte lane; o_hit, o_data (whole word), o_byte (lane).
module jtpopeye_romarb_cache
    import jtpopeye_romarb_pkg::*;
#(
    parameter int W = TAG_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_we,
    input  logic [W-1:0] i_wtag,
    input  logic [31:0]  i_wdata,
    input  logic         i_en,
    input  logic [W-1:0] i_tag,
    input  logic [1:0]   i_bsel,
    output logic         o_hit,
    output logic [31:0]  o_data,
    output logic [7:0]   o_byte
);

    logic         r_valid;
    logic [W-1:0] r_tag;
    logic [31:0]  r_data;

    // Invalidation wins over a fill so a download always leaves the entry empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_we) begin
            r_valid <= 1'b1;
            r_tag   <= i_wtag;
            r_data  <= i_wdata;
        end
    end

    assign o_hit  = i_en & r_valid & (r_tag == i_tag);
    assign o_data = r_data;
    assign o_byte = byte_sel(r_data, i_bsel);

endmodule

// File: rtl/jtpopeye_romarb.sv
// jtpopeye_romarb: SDRAM read arbiter between the main CPU ROM and object ROM
// Ports: clk, rst_n (async active-low); downloading blocks reads and flushes;
// cpu_cs/cpu_addr -> cpu_dout/cpu_ok byte port; obj_addr -> obj_data/obj_ok
// word port; sdram_addr/sdram_rd request, sdram_ack/sdram_rdy/sdram_din reply.
module jtpopeye_romarb
    import jtpopeye_romarb_pkg::*;
#(
    parameter logic [21:0] CPU_OFFSET = CPU_OFFSET_DEF,
    parameter logic [21:0] OBJ_OFFSET = OBJ_OFFSET_DEF,
    parameter int          STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic        cpu_cs,
    input  logic [14:0] cpu_addr,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ok,
    input  logic [12:0] obj_addr,
    output logic [31:0] obj_data,
    output logic        obj_ok,
    output logic [21:0] sdram_addr,
    output logic        sdram_rd,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [31:0] sdram_din
);

    state_t             r_state;
    logic               r_sel_cpu;
    logic [TAG_W-1:0]   r_tag;
    logic [1:0]         r_starve;
    logic               r_drop;
    logic               w_cpu_pend;
    logic               w_obj_pend;
    logic               w_cpu_win;
    logic               w_fill;
    logic [31:0]        w_cpu_word_unused;
    logic [7:0]         w_obj_byte_unused;

    assign w_cpu_pend = cpu_cs & ~cpu_ok;
    assign w_obj_pend = ~obj_ok;
    // Object fetches win ties until the CPU has been passed over STARVE_MAX times
    assign w_cpu_win  = w_cpu_pend & (~w_obj_pend | (r_starve == 2'(STARVE_MAX)));
    // A fill that overlapped a download carries stale ROM contents and is dropped
    assign w_fill     = (r_state == ST_WAIT_RDY) & sdram_rdy & ~r_drop & ~downloading;

    jtpopeye_romarb_cache u_cpu_cache (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (downloading),
        .i_we    (w_fill & r_sel_cpu),
        .i_wtag  (r_tag),
        .i_wdata (sdram_din),
        .i_en    (cpu_cs),
        .i_tag   (cpu_addr[14:2]),
        .i_bsel  (cpu_addr[1:0]),
        .o_hit   (cpu_ok),
        .o_data  (w_cpu_word_unused),
        .o_byte  (cpu_dout)
    );

    jtpopeye_romarb_cache u_obj_cache (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (downloading),
        .i_we    (w_fill & ~r_sel_cpu),
        .i_wtag  (r_tag),
        .i_wdata (sdram_din),
        .i_en    (1'b1),
        .i_tag   (obj_addr),
        .i_bsel  (2'b00),
        .o_hit   (obj_ok),
        .o_data  (obj_data),
        .o_byte  (w_obj_byte_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            sdram_rd   <= 1'b0;
            sdram_addr <= '0;
            r_sel_cpu  <= 1'b0;
            r_tag      <= '0;
            r_starve   <= '0;
            r_drop     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (!downloading && (w_cpu_pend || w_obj_pend)) begin
                        r_sel_cpu  <= w_cpu_win;
                        r_tag      <= w_cpu_win ? cpu_addr[14:2] : obj_addr;
                        sdram_addr <= w_cpu_win ? CPU_OFFSET + {9'd0, cpu_addr[14:2]}
                                                : OBJ_OFFSET + {9'd0, obj_addr};
                        sdram_rd   <= 1'b1;
                        r_starve   <= w_cpu_win ? 2'd0 :
                                      (w_cpu_pend && r_starve != 2'd3) ? r_starve + 2'd1 : r_starve;
                        r_state    <= ST_WAIT_ACK;
                    end
                end
                // rdy is ignored here, so a simultaneous ack+rdy counts as ack only
                ST_WAIT_ACK: begin
                    if (downloading) r_drop <= 1'b1;
                    if (sdram_ack) begin
                        sdram_rd <= 1'b0;
                        r_state  <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (downloading) r_drop <= 1'b1;
                    if (sdram_rdy) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/jtpopeye_romarb.md
JTPOPEYE_ROMARB -- requirements
Module: jtpopeye_romarb

Interface
REQ-001 Parameter CPU_OFFSET, default 22'h00_0000, SDRAM word base of the main CPU ROM.
REQ-002 Parameter OBJ_OFFSET, default 22'h00_4000, SDRAM word base of the object ROM.
REQ-003 Parameter STARVE_MAX, default 2, consecutive CPU arbitration losses tolerated.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 downloading  in  1  ROM download in progress; blocks new SDRAM reads.
REQ-007 cpu_cs  in  1  CPU ROM access request, level.
REQ-008 cpu_addr  in  15  CPU ROM byte address.
REQ-009 cpu_dout  out  8  CPU ROM byte.
REQ-010 cpu_ok  out  1  cpu_dout valid for the current cpu_addr.
REQ-011 obj_addr  in  13  object ROM 32-bit word address; no strobe.
REQ-012 obj_data  out  32  object ROM word.
REQ-013 obj_ok  out  1  obj_data valid for the current obj_addr.
REQ-014 sdram_addr  out  22  SDRAM 32-bit word address.
REQ-015 sdram_rd  out  1  read request, held until sdram_ack.
REQ-016 sdram_ack  in  1  one-cycle pulse; request accepted.
REQ-017 sdram_rdy  in  1  one-cycle pulse; sdram_din valid.
REQ-018 sdram_din  in  32  SDRAM read data.

Function
REQ-019 Each requester SHALL hold a one-entry cache: tag (word address), 32-bit data, valid bit.
REQ-020 CPU pending = cpu_cs & ~(valid & tag==cpu_addr[14:2]); obj pending = ~(valid & tag==obj_addr).
REQ-021 cpu_ok and obj_ok SHALL be combinational hit signals; cpu_ok SHALL also require cpu_cs.
REQ-022 cpu_dout SHALL be the cached byte cpu_addr[1:0] (0 = bits 7:0, 3 = bits 31:24).
REQ-023 FSM states: IDLE, WAIT_ACK, WAIT_RDY.
REQ-024 IDLE: if ~downloading and a requester is pending, latch the winner, drive sdram_addr and sdram_rd=1, and go to WAIT_ACK in the next cycle.
REQ-025 Arbitration: obj SHALL win a tie unless the starvation counter == STARVE_MAX, in which case the CPU wins.
REQ-026 Starvation counter (2 bits, saturating): increments when the CPU loses a tie; clears when the CPU is granted.
REQ-027 sdram_addr = CPU_OFFSET + cpu_addr[14:2] or OBJ_OFFSET + obj_addr; 22-bit modulo addition.
REQ-028 WAIT_ACK: on sdram_ack, drop sdram_rd in the same edge and go to WAIT_RDY; sdram_addr is held.
REQ-029 WAIT_RDY: on sdram_rdy, write sdram_din and the latched tag to the winner's cache, set valid, and return to IDLE.
REQ-030 The served requester's ok SHALL rise on the cycle after sdram_rdy if its address is unchanged; total latency is the IDLE cycle plus the ack wait plus the rdy wait plus 1.
REQ-031 An address change during WAIT_ACK or WAIT_RDY SHALL NOT abort the transaction; the fill completes with the latched tag, and a new miss is served from IDLE.
REQ-032 Simultaneous sdram_ack and sdram_rdy in WAIT_ACK SHALL be treated as ack only.
REQ-033 downloading rising: any in-flight transaction completes, but its data is discarded; both valid bits clear; no new request is issued while downloading is high.
REQ-034 Back-to-back: from IDLE after a fill, the next pending request issues without an extra idle cycle beyond the IDLE state.

Reset
REQ-035 While rst_n is low: state IDLE; sdram_rd=0; sdram_addr=0; both valid bits=0; starvation counter=0; cpu_ok=0; obj_ok=0; cpu_dout=0; obj_data=0.
REQ-036 Reset asserted mid-transaction SHALL abandon the transaction immediately; late ack or rdy pulses in IDLE SHALL be ignored.

Structure
REQ-037 The state encoding and the default offsets SHALL live in the shared jtpopeye package.
REQ-038 A sub-module jtpopeye_romarb_cache (tag/data/valid, hit, byte select) SHALL be instantiated twice.

Verification
REQ-039 Reset, then cpu_cs=1, cpu_addr=15'h0005, ack after 2 cycles, rdy after 4 with 32'hAABBCCDD -> sdram_addr=22'h000001; cpu_dout=8'hCC; cpu_ok high the cycle after rdy.
REQ-040 obj_addr=13'h0010 and cpu_addr=15'h0100 both missing -> issue order obj (22'h004010), then CPU (22'h000040).
REQ-041 CPU misses continuously while obj_addr changes every fill -> CPU is granted after at most 2 obj fills.
REQ-042 downloading raised during WAIT_RDY -> the rdy data is not cached; obj_ok=0; sdram_rd stays 0 until downloading falls.
REQ-043 obj_addr changes during WAIT_RDY -> the old tag fills, obj_ok stays 0, and a second read is issued for the new address.
REQ-044 rst_n pulsed low in WAIT_ACK -> sdram_rd=0 asynchronously; a subsequent stray sdram_rdy leaves both caches invalid.
